icache_axi_refill: RTL and testbench

Memory-side responder for the icache refill interface (rd_req/rd_addr in, ret_valid/ret_data out). On a refill request it issues one 8-beat AXI4 INCR read burst for the 32-byte line containing rd_addr. It collects the eight 32-bit beats into a 256-bit line buffer and returns the line as a single-cycle ret_valid pulse. It sits between the icache and the AXI interconnect/arbiter.

---
 rtl/icache_axi_refill.sv | 118 +++++++++++
 tb/tb_icache_axi_refill.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_refill.sv
// Icache line refill engine: one 8-beat AXI4 INCR read per miss, beats gathered
// into a 256-bit line and handed back as a single-cycle ret_valid_o pulse.
//
// state  | meaning
// IDLE   | waiting for rd_req_i; ret_data_o holds the previous line
// AR     | arvalid_o high with the line address until arready_i
// R      | accepting read beats into the line buffer
// RESP   | one-cycle ret_valid_o / refill_err_o pulse
module icache_axi_refill #(
   parameter int                  ID_WIDTH = 4,
   parameter logic [ID_WIDTH-1:0] AXI_ID   = 4'h0,
   parameter int                  BEATS    = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  rd_req_i,
   input  logic [31:0]           rd_addr_i,
   output logic                  ret_valid_o,
   output logic [32*BEATS-1:0]   ret_data_o,
   output logic                  busy_o,
   output logic                  refill_err_o,
   output logic [ID_WIDTH-1:0]   arid_o,
   output logic [31:0]           araddr_o,
   output logic [7:0]            arlen_o,
   output logic [2:0]            arsize_o,
   output logic [1:0]            arburst_o,
   output logic                  arvalid_o,
   input  logic                  arready_i,
   input  logic [ID_WIDTH-1:0]   rid_i,
   input  logic [31:0]           rdata_i,
   input  logic [1:0]            rresp_i,
   input  logic                  rlast_i,
   input  logic                  rvalid_i,
   output logic                  rready_o
);

   localparam int CNT_W = $clog2(BEATS);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [32*BEATS-1:0]  buf_q, buf_d;
   logic                 err_q, err_d;
   logic [31:0]          addr_q, addr_d;
   logic                 last_beat;
   logic                 unused_addr_lsb;

   assign unused_addr_lsb = ^rd_addr_i[4:0];
   assign last_beat       = (cnt_q == CNT_W'(BEATS-1));

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         buf_q   <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      err_d   = err_q;
      addr_d  = addr_q;
      case (state_q)
         S_IDLE: begin
            if (rd_req_i) begin
               addr_d  = {rd_addr_i[31:5], 5'b0};
               cnt_d   = '0;
               buf_d   = '0;
               err_d   = 1'b0;
               state_d = S_AR;
            end
         end
         S_AR: begin
            if (arready_i) state_d = S_R;
         end
         S_R: begin
            if (rvalid_i) begin
               buf_d[{cnt_q, 5'b0} +: 32] = rdata_i;
               cnt_d = cnt_q + 1'b1;
               // a burst whose rlast does not line up with beat 7 is malformed
               if (rresp_i != 2'b00 || rid_i != AXI_ID || rlast_i != last_beat)
                  err_d = 1'b1;
               if (rlast_i || last_beat) state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign arvalid_o    = (state_q == S_AR);
   assign rready_o     = (state_q == S_R);
   assign ret_valid_o  = (state_q == S_RESP);
   assign refill_err_o = (state_q == S_RESP) && err_q;
   assign busy_o       = (state_q != S_IDLE);
   assign ret_data_o   = buf_q;
   assign araddr_o     = addr_q;
   assign arid_o       = AXI_ID;
   assign arlen_o      = 8'(BEATS-1);
   assign arsize_o     = 3'b010;
   assign arburst_o    = 2'b01;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Bench for icache_axi_refill: directed refills against an AXI slave model,
// with AR and return-line scoreboards checked from independent monitors.
module tb_icache_axi_refill;

   logic          clk = 1'b0;
   logic          reset_i, rd_req_i;
   logic [31:0]   rd_addr_i;
   logic          ret_valid_o, busy_o, refill_err_o;
   logic [255:0]  ret_data_o;
   logic [3:0]    arid_o, rid_i;
   logic [31:0]   araddr_o, rdata_i;
   logic [7:0]    arlen_o;
   logic [2:0]    arsize_o;
   logic [1:0]    arburst_o, rresp_i;
   logic          arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;

   always #5 clk = ~clk;

   icache_axi_refill dut (
      .clk_i(clk), .reset_i(reset_i), .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
      .ret_valid_o(ret_valid_o), .ret_data_o(ret_data_o), .busy_o(busy_o),
      .refill_err_o(refill_err_o), .arid_o(arid_o), .araddr_o(araddr_o),
      .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
      .arvalid_o(arvalid_o), .arready_i(arready_i), .rid_i(rid_i), .rdata_i(rdata_i),
      .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
   );

   typedef struct {
      logic [255:0] line;
      logic         err;
      int           lat;
   } ret_t;

   ret_t         ret_q[$];
   logic [31:0]  ar_q[$];
   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   int           ar_hs_cnt = 0;
   logic         prev_rv = 1'b0;

   logic [31:0]  cfg_base = '0;
   int           cfg_errb = -1;
   int           cfg_lastb = 7;
   bit           cfg_gaps = 1'b0;
   logic [3:0]   cfg_rid = '0;
   int           ar_left = 0;
   int           bi = 0;
   int           gap_left = 0;
   bit           r_act = 1'b0;
   bit           kill = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [255:0] mk_line(input logic [31:0] base, input int nwords);
      logic [255:0] l;
      l = '0;
      for (int i = 0; i < 8; i++)
         if (i < nwords) l[i*32 +: 32] = base + 32'(i);
      return l;
   endfunction

   // AXI slave model
   initial begin
      logic ar_hs, r_hs;
      arready_i = 0; rvalid_i = 0; rdata_i = 0; rresp_i = 0; rlast_i = 0; rid_i = 0;
      forever begin
         @(negedge clk);
         ar_hs = arvalid_o && arready_i;
         r_hs  = rvalid_i && rready_o;
         @(posedge clk); #1;
         if (gap_left > 0) gap_left--;
         if (kill) begin
            r_act = 0; gap_left = 0; kill = 0;
         end else begin
            if (ar_hs) begin r_act = 1; bi = 0; gap_left = 0; end
            if (r_hs) begin
               if (rlast_i || bi == 7) r_act = 0;
               bi++;
               if (cfg_gaps) gap_left = 2;
            end
         end
         arready_i = 0;
         if (arvalid_o) begin
            if (ar_left > 0) ar_left--;
            else arready_i = 1;
         end
         if (r_act && gap_left == 0) begin
            rvalid_i = 1;
            rdata_i  = cfg_base + 32'(bi);
            rresp_i  = (bi == cfg_errb) ? 2'b10 : 2'b00;
            rlast_i  = (bi == cfg_lastb);
            rid_i    = cfg_rid;
         end else begin
            rvalid_i = 0; rlast_i = 0; rresp_i = 0;
         end
      end
   end

   // monitors
   initial begin
      ret_t e;
      forever begin
         @(negedge clk);
         if (arvalid_o === 1'b1) begin
            if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
            else chk("araddr", araddr_o, ar_q[0]);
            if (arready_i) begin
               ar_hs_cnt++;
               chk("arlen", arlen_o, 8'd7);
               chk("arsize", arsize_o, 3'd2);
               chk("arburst", arburst_o, 2'd1);
               chk("arid", arid_o, 4'h0);
               if (ar_q.size() > 0) void'(ar_q.pop_front());
            end
         end
         if (ret_valid_o === 1'b1) begin
            chk("ret_single_cycle", prev_rv, 0);
            chk("rready_in_resp", rready_o, 0);
            if (ret_q.size() == 0) chk("ret_unexpected", 1, 0);
            else begin
               e = ret_q.pop_front();
               chk("ret_data", ret_data_o, e.line);
               chk("refill_err", refill_err_o, e.err);
               if (e.lat >= 0) chk("ret_latency_cycle", cyc, e.lat);
            end
         end
         prev_rv = ret_valid_o;
      end
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic wait_ret();
      int k;
      k = 0;
      while (ret_valid_o !== 1'b1 && k < 200) begin tick(); k++; end
      if (k >= 200) chk("ret_timeout", 0, 1);
   endtask

   task automatic refill(input logic [31:0] addr, input logic [31:0] base, input int arw,
                         input bit gaps, input int errb, input int lastb, input logic [3:0] ridv,
                         input logic [255:0] line, input logic err, input int lat);
      ret_t r;
      cfg_base = base; cfg_gaps = gaps; cfg_errb = errb; cfg_lastb = lastb; cfg_rid = ridv;
      ar_left = arw; bi = 0;
      ar_q.push_back({addr[31:5], 5'b0});
      r.line = line; r.err = err; r.lat = (lat < 0) ? -1 : cyc + lat;
      ret_q.push_back(r);
      rd_req_i = 1; rd_addr_i = addr;
      tick();
      wait_ret();
      rd_req_i = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, k;
      reset_i = 0; rd_req_i = 0; rd_addr_i = 32'h0;
      repeat (3) tick();
      chk("rst_ret_valid", ret_valid_o, 0);
      chk("rst_refill_err", refill_err_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_arvalid", arvalid_o, 0);
      chk("rst_rready", rready_o, 0);
      chk("rst_araddr", araddr_o, 0);
      chk("rst_ret_data", ret_data_o, 0);
      reset_i = 1;
      repeat (2) tick();

      // zero-wait burst
      refill(32'h1C00_0034, 32'hA000_0000, 0, 0, -1, 7, 4'h0,
             mk_line(32'hA000_0000, 8), 1'b0, 10);
      tick();
      chk("busy_after_resp", busy_o, 0);
      tick();
      chk("ret_data_held", ret_data_o, mk_line(32'hA000_0000, 8));

      // backpressure on AR and R
      refill(32'h1C00_0034, 32'hA000_0000, 3, 1, -1, 7, 4'h0,
             mk_line(32'hA000_0000, 8), 1'b0, -1);
      repeat (2) tick();

      // error response on beat 4
      refill(32'h0000_3004, 32'hC000_0000, 0, 0, 4, 7, 4'h0,
             mk_line(32'hC000_0000, 8), 1'b1, 10);
      repeat (2) tick();

      // early rlast on beat 5
      refill(32'h4000_007F, 32'hD000_0000, 0, 0, -1, 5, 4'h0,
             mk_line(32'hD000_0000, 6), 1'b1, 8);
      tick();
      chk("no_rready_after_early_last", rready_o, 0);
      tick();

      // wrong rid
      refill(32'h7000_0000, 32'hE000_0000, 0, 0, -1, 7, 4'h3,
             mk_line(32'hE000_0000, 8), 1'b1, 10);
      repeat (2) tick();

      // rlast never asserted
      refill(32'h8000_0008, 32'h9000_0000, 0, 0, -1, -1, 4'h0,
             mk_line(32'h9000_0000, 8), 1'b1, 10);
      repeat (2) tick();

      // reset after beat 3
      cfg_base = 32'h5500_0000; cfg_gaps = 0; cfg_errb = -1; cfg_lastb = 7; cfg_rid = 0;
      ar_left = 0; bi = 0;
      ar_q.push_back(32'h5000_0000);
      rd_req_i = 1; rd_addr_i = 32'h5000_0010;
      k = 0;
      tick();
      while (bi < 4 && k < 50) begin tick(); k++; end
      if (k >= 50) chk("reset_scn_timeout", 0, 1);
      reset_i = 0; rd_req_i = 0; kill = 1;
      tick();
      chk("midrst_busy", busy_o, 0);
      chk("midrst_rready", rready_o, 0);
      chk("midrst_arvalid", arvalid_o, 0);
      chk("midrst_ret_valid", ret_valid_o, 0);
      chk("midrst_ret_data", ret_data_o, 0);
      reset_i = 1;
      repeat (3) tick();
      refill(32'h0000_1000, 32'hB000_0000, 0, 0, -1, 7, 4'h0,
             mk_line(32'hB000_0000, 8), 1'b0, 10);
      repeat (2) tick();

      // back-to-back misses
      n0 = ar_hs_cnt;
      refill(32'h6000_0000, 32'hF000_0000, 0, 0, -1, 7, 4'h0,
             mk_line(32'hF000_0000, 8), 1'b0, 10);
      repeat (2) tick();
      refill(32'h0000_2040, 32'h1234_0000, 0, 0, -1, 7, 4'h0,
             mk_line(32'h1234_0000, 8), 1'b0, 10);
      repeat (3) tick();
      chk("b2b_ar_handshakes", ar_hs_cnt - n0, 2);

      chk("ar_queue_drained", ar_q.size(), 0);
      chk("ret_queue_drained", ret_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
